load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the pipeline MEM stage and DataMemory. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests
//  into word-indexed DataMemory accesses. Sub-word stores use a read-modify-write sequence, and loads are sign- or
//  zero-extended. Misaligned and out-of-range requests are rejected without touching memory.
//  Request and response use valid/ready handshakes, so the pipeline stalls on req_ready/resp_valid.
// PARAMETERS
//  ADDR_LIMIT  32'h0000_0400  byte-address bound; req_addr >= ADDR_LIMIT -> error response
//  DATA_W      32             data width; fixed at 32, any other value is unsupported
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   synchronous, active-low reset (sampled on posedge clk)
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept (high only in IDLE)
//  req_we      in   1   1 = store, 0 = load
//  req_size    in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (store uses [1:0])
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; low bytes used for B/H
//  resp_valid  out  1   response present; held until resp_ready
//  resp_ready  in   1   consumer accepts response
//  resp_rdata  out  32  extended load data (0 for stores/errors)
//  resp_err    out  1   misaligned or out-of-range
//  mem_addr    out  32  word index to DataMemory = addr[31:2]
//  mem_read    out  1   DataMemory read strobe
//  mem_write   out  1   DataMemory write strobe
//  mem_wdata   out  32  DataMemory write_data
//  mem_rdata   in   32  DataMemory read_data; valid the cycle after mem_read
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_wdata, mem_addr = 0.
//  Reset mid-operation aborts the sequence with no further memory strobe. A write strobe already issued is not undone.
//  FSM states: IDLE, READ, MERGE, WRITE, RESP.
//   IDLE: req_ready=1. On req_valid, latch we/size/addr/wdata.
//         misaligned (H with addr[0]=1; W with addr[1:0]!=0) or addr >= ADDR_LIMIT -> RESP, err=1.
//         SW -> WRITE. All other requests -> READ.
//   READ: mem_read=1 for exactly one cycle -> MERGE.
//   MERGE: sample mem_rdata.
//         Load: select lane addr[1:0] (B) or addr[1] (H), extend per size -> RESP.
//         SB/SH: replace the selected lane(s) in the read word with wdata[7:0]/[15:0] -> WRITE.
//   WRITE: mem_write=1 for one cycle with the merged/full word -> RESP.
//   RESP: resp_valid=1; outputs stable until resp_ready=1 -> IDLE. The next request is accepted no earlier than the
//         following cycle.
//  Latency (accept edge = T, resp_valid high from): SW T+2, loads T+3, SB/SH T+4, error T+1.
//  At most one outstanding request. req_* is ignored outside IDLE.
//  mem_read and mem_write are never high together. Neither is asserted in IDLE, RESP or on an error.
//  mem_addr is held at the latched word index from READ through WRITE.
//  Sign extension: B copies bit 7, H copies bit 15; BU/HU zero-fill. Reserved sizes (011, 110, 111) -> err=1.
// STRUCTURE
//  Shared package lsu_pkg:
//   - funct3 size constants SZ_B/SZ_H/SZ_W/SZ_BU/SZ_HU
//   - FSM state encoding
//   - function is_misaligned(size, addr[1:0])
//  Sub-module lsu_lane_align (combinational): load extract+extend and store lane merge, driven by addr[1:0] and size.
//  Top level holds the FSM, request latches and response registers.
// TESTING (with DataMemory attached)
//  - Reset: hold rst=0 for 2 cycles -> req_ready=1, resp_valid=0, mem_read=mem_write=0.
//  - SW 0x12345678 @0x4, then LW @0x4 -> mem_write with mem_addr=1; LW resp_rdata=0x12345678, err=0, latency 3.
//  - SB 0xAB @0x5 over word 0x12345678 -> RMW writes 0x1234AB78; then LB @0x5 -> 0xFFFFFFAB, LBU @0x5 -> 0x000000AB.
//  - SH 0x8001 @0x6, LH @0x6 -> 0xFFFF8001; LHU -> 0x00008001; word @0x4 reads 0x8001AB78.
//  - LW @0x6 and LH @0x3 -> resp_err=1 at T+1, no mem strobe; addr 0x400 -> err=1.
//  - Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0. Assert rst=0 during READ -> IDLE, no
//    mem_write.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM
// state encoding and request classification helpers.
package lsu_pkg;

  // funct3 access-size codes
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // Halfwords need an even address, words a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Any funct3 outside the five defined access sizes.
  function automatic logic is_reserved(input logic [2:0] size);
    return !(size == SZ_B || size == SZ_H || size == SZ_W ||
             size == SZ_BU || size == SZ_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte/halfword
// of a memory word for loads, and merges store data into a word for SB/SH.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] rword,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, load extension and store merge
  always_comb begin
    byte_v    = rword[7:0];
    half_v    = addr_lo[1] ? rword[31:16] : rword[15:0];
    load_data = rword;
    merged    = rword;

    case (addr_lo)
      2'd0:    byte_v = rword[7:0];
      2'd1:    byte_v = rword[15:8];
      2'd2:    byte_v = rword[23:16];
      default: byte_v = rword[31:24];
    endcase

    case (size)
      SZ_B:    load_data = {{24{byte_v[7]}}, byte_v};
      SZ_BU:   load_data = {24'h0, byte_v};
      SZ_H:    load_data = {{16{half_v[15]}}, half_v};
      SZ_HU:   load_data = {16'h0, half_v};
      default: load_data = rword;
    endcase

    case (size[1:0])
      2'b00: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (addr_lo[1]) merged[31:16] = wdata;
        else            merged[15:0]  = wdata;
      end
      default: merged = rword;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-indexed DataMemory.
// Sub-word stores are done as read-modify-write; bad requests never touch memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [2:0]  state;
  logic        op_we;
  logic [2:0]  op_size;
  logic [1:0]  op_lo;
  logic [15:0] op_wdata;
  logic [2:0]  eff_size;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Stores only look at size[1:0]; normalise so one classification covers both
  always_comb begin
    eff_size = req_we ? {1'b0, req_size[1:0]} : req_size;
    req_bad  = (req_addr >= ADDR_LIMIT) || is_reserved(eff_size) ||
               is_misaligned(eff_size, req_addr[1:0]);
  end

  lsu_lane_align u_align (
    .addr_lo   (op_lo),
    .size      (op_size),
    .rword     (mem_rdata),
    .wdata     (op_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // Handshake and memory strobes decode directly from the state
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    mem_read   = (state == ST_READ);
    mem_write  = (state == ST_WRITE);
  end

  // FSM, request latches and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_we      <= 1'b0;
      op_size    <= '0;
      op_lo      <= '0;
      op_wdata   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_we      <= req_we;
            op_size    <= eff_size;
            op_lo      <= req_addr[1:0];
            op_wdata   <= req_wdata[15:0];
            resp_rdata <= '0;
            resp_err   <= req_bad;
            if (req_bad) begin
              state <= ST_RESP;
            end else begin
              mem_addr <= {2'b00, req_addr[31:2]};
              if (req_we && eff_size == SZ_W) begin
                mem_wdata <= req_wdata;
                state     <= ST_WRITE;
              end else begin
                state <= ST_READ;
              end
            end
          end
        end
        ST_READ:  state <= ST_MERGE;
        ST_MERGE: begin
          if (op_we) begin
            mem_wdata <= merged;
            state     <= ST_WRITE;
          end else begin
            resp_rdata <= load_data;
            state      <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  if (resp_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with an attached DataMemory model
// and a byte-array reference model of memory contents.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_LIMIT(32'h0000_0400), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DataMemory: synchronous read, data valid the cycle after mem_read
  logic [31:0] dmem [0:255];
  initial for (int i = 0; i < 256; i++) dmem[i] = '0;
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= dmem[mem_addr[7:0]];
  end

  // Strobe monitor
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] strobe_addr = '0;
  always @(negedge clk) begin
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
    if (mem_read || mem_write) strobe_addr = mem_addr;
  end

  // Reference memory, byte granular
  logic [7:0] ref_mem [0:1023];
  initial for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, output logic [31:0] rdata_o);
    logic [2:0]  eff;
    int          nbytes;
    logic        bad;
    int          exp_lat, exp_rd, exp_wr, lat, rd0, wr0;
    logic [31:0] exp_data, rd;
    logic        er, stable;

    eff    = we ? {1'b0, size[1:0]} : size;
    nbytes = (eff[1:0] == 2'b00) ? 1 : (eff[1:0] == 2'b01) ? 2 : 4;
    bad    = (addr >= 32'h400) ||
             !(eff == 3'b000 || eff == 3'b001 || eff == 3'b010 || eff == 3'b100 || eff == 3'b101) ||
             ((addr % nbytes) != 0);
    exp_lat = bad ? 1 : (we ? ((nbytes == 4) ? 2 : 4) : 3);
    exp_rd  = (!bad && !(we && nbytes == 4)) ? 1 : 0;
    exp_wr  = (!bad && we) ? 1 : 0;
    exp_data = '0;
    if (!bad && !we) begin
      for (int i = 0; i < nbytes; i++) exp_data |= 32'(ref_mem[addr + i]) << (8 * i);
      if (!eff[2] && nbytes < 4 && exp_data[8*nbytes-1])
        exp_data |= ~((32'd1 << (8 * nbytes)) - 32'd1);
    end

    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Garbage while busy must be ignored
    req_we = 1'($urandom); req_size = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;

    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (resp_valid === 1'b1) break;
    end
    req_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    rd = resp_rdata; er = resp_err;

    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) chk("stall_stable", 32'(stable), 32'd1);

    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;

    chk("rdata", rd, exp_data);
    chk("err", 32'(er), 32'(bad));
    chk("read_strobes", 32'(rd_cnt - rd0), 32'(exp_rd));
    chk("write_strobes", 32'(wr_cnt - wr0), 32'(exp_wr));
    chk("ready_after", 32'(req_ready), 32'd1);
    if (exp_rd + exp_wr > 0) chk("strobe_addr", strobe_addr, addr >> 2);

    if (!bad && we)
      for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    rdata_o = rd;
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  sizes [0:6];
    int          wr0;
    sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b010; sizes[3] = 3'b100;
    sizes[4] = 3'b101; sizes[5] = 3'b011; sizes[6] = 3'b110;

    // Reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed sequence
    do_req(1'b1, 3'b010, 32'h4, 32'h12345678, 0, r);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 0, r);
    chk("lw_4", r, 32'h12345678);
    do_req(1'b1, 3'b000, 32'h5, 32'hFFFF_FFAB, 0, r);
    chk("sb_rmw_word", dmem[1], 32'h1234AB78);
    do_req(1'b0, 3'b000, 32'h5, 32'h0, 0, r);
    chk("lb_5", r, 32'hFFFFFFAB);
    do_req(1'b0, 3'b100, 32'h5, 32'h0, 0, r);
    chk("lbu_5", r, 32'h000000AB);
    do_req(1'b1, 3'b001, 32'h6, 32'h0000_8001, 0, r);
    do_req(1'b0, 3'b001, 32'h6, 32'h0, 0, r);
    chk("lh_6", r, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h6, 32'h0, 0, r);
    chk("lhu_6", r, 32'h00008001);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 5, r);
    chk("lw_4_after", r, 32'h8001AB78);
    do_req(1'b0, 3'b010, 32'h6, 32'h0, 0, r);
    do_req(1'b0, 3'b001, 32'h3, 32'h0, 0, r);
    do_req(1'b0, 3'b010, 32'h400, 32'h0, 2, r);
    do_req(1'b0, 3'b011, 32'h8, 32'h0, 0, r);
    do_req(1'b1, 3'b010, 32'h3FC, 32'hDEADBEEF, 0, r);
    do_req(1'b0, 3'b000, 32'h3FF, 32'h0, 0, r);

    // Reset while in READ of an SB: sequence aborts with no write
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'b000; req_addr = 32'h8; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wr0 = wr_cnt;
    chk("abort_in_read", 32'(mem_read), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("abort_word", dmem[2], ref_word(2));

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic        we;
      logic [2:0]  sz;
      logic [31:0] ad;
      we = 1'($urandom_range(0, 1));
      sz = sizes[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) ad = 32'($urandom_range(32'h400, 32'h4FF));
      else                           ad = 32'($urandom_range(0, 63));
      do_req(we, sz, ad, $urandom, ($urandom_range(0, 7) == 0) ? 3 : 0, r);
    end

    for (int w = 0; w < 16; w++) chk("final_word", dmem[w], ref_word(w));
    chk("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
